ysyx_23060187_inst_mem_responder: RTL and testbench

//  Instruction-memory responder: the memory-side end of the core's pc -> inst fetch interface.

---
 rtl/ysyx_23060187_fetch_pkg.sv | 26 ++
 rtl/ysyx_23060187_imem_array.sv | 31 +++
 rtl/ysyx_23060187_inst_mem_responder.sv | 109 ++++++++++
 tb/tb_ysyx_23060187_inst_mem_responder.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/ysyx_23060187_fetch_pkg.sv
// Shared types and constants for the instruction-fetch responder.
// Includes the fetch state encoding, the EBREAK fallback word and a fetch-address check.
package ysyx_23060187_fetch_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } fetch_state_e;

    localparam logic [31:0] INST_EBREAK       = 32'h0010_0073;
    localparam logic [31:0] DEFAULT_BASE_ADDR = 32'h8000_0000;
    localparam int unsigned LAT_CNT_W         = 4;

    // A fetch is bad when it is not word aligned or its word index falls past the array.
    function automatic logic fetch_addr_bad(
        input logic [31:0] pc,
        input logic [31:0] base,
        input logic [31:0] depth
    );
        logic [31:0] word_idx;
        word_idx = (pc - base) >> 2;
        return (pc[1:0] != 2'b00) || (word_idx >= depth);
    endfunction

endpackage

// File: rtl/ysyx_23060187_imem_array.sv
// Instruction storage: one synchronous read-first read port and one write port.
// A write and a read of the same word on the same edge returns the old word.
module ysyx_23060187_imem_array #(
    parameter int unsigned DEPTH_WORDS = 1024,
    localparam int unsigned AW = $clog2(DEPTH_WORDS)
) (
    input  logic          clk,
    input  logic          rd_en,
    input  logic [AW-1:0] rd_idx,
    output logic [31:0]   rd_data,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_idx,
    input  logic [31:0]   wr_data
);

    logic [31:0] mem_q [DEPTH_WORDS];
    logic [31:0] rd_data_q;

    // Storage is never reset so a program image loaded during reset survives it.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_idx] <= wr_data;
        end
        if (rd_en) begin
            rd_data_q <= mem_q[rd_idx];
        end
    end

    assign rd_data = rd_data_q;

endmodule

// File: rtl/ysyx_23060187_inst_mem_responder.sv
// Memory-side end of the pc -> inst fetch handshake: one in-flight fetch with fixed latency,
// response held until taken, misaligned/out-of-range fetches answered with EBREAK.
module ysyx_23060187_inst_mem_responder
    import ysyx_23060187_fetch_pkg::*;
#(
    parameter int unsigned DEPTH_WORDS = 1024,
    parameter int unsigned LATENCY     = 2,
    parameter logic [31:0] BASE_ADDR   = DEFAULT_BASE_ADDR,
    localparam int unsigned AW         = $clog2(DEPTH_WORDS)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          req_valid,
    output logic          req_ready,
    input  logic [31:0]   req_pc,
    output logic          rsp_valid,
    input  logic          rsp_ready,
    output logic [31:0]   rsp_inst,
    output logic          rsp_err,
    input  logic          load_en,
    input  logic [AW-1:0] load_addr,
    input  logic [31:0]   load_data
);

    localparam logic [LAT_CNT_W-1:0] LAT_START = LAT_CNT_W'(LATENCY - 1);
    localparam logic [31:0]          DEPTH_32  = 32'(DEPTH_WORDS);

    fetch_state_e         state_q, state_d;
    logic [LAT_CNT_W-1:0] cnt_q, cnt_d;
    logic                 err_q, err_d;
    logic                 accept;
    logic [31:0]          word_idx;
    logic                 addr_bad;
    logic [31:0]          array_word;

    assign word_idx  = (req_pc - BASE_ADDR) >> 2;
    assign addr_bad  = fetch_addr_bad(req_pc, BASE_ADDR, DEPTH_32);
    assign req_ready = (state_q == IDLE) || ((state_q == RESP) && rsp_ready);
    assign accept    = req_valid && req_ready;
    assign rsp_valid = (state_q == RESP);

    ysyx_23060187_imem_array #(
        .DEPTH_WORDS (DEPTH_WORDS)
    ) u_array (
        .clk     (clk),
        .rd_en   (accept),
        .rd_idx  (word_idx[AW-1:0]),
        .rd_data (array_word),
        .wr_en   (load_en),
        .wr_idx  (load_addr),
        .wr_data (load_data)
    );

    // An accept can only occur in IDLE or on a RESP handshake, so it overrides the case result.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        err_d   = err_q;
        case (state_q)
            IDLE: ;
            WAIT: begin
                if (cnt_q == LAT_CNT_W'(1)) begin
                    state_d = RESP;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q - LAT_CNT_W'(1);
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        if (accept) begin
            err_d = addr_bad;
            if (LATENCY == 1) begin
                state_d = RESP;
                cnt_d   = '0;
            end else begin
                state_d = WAIT;
                cnt_d   = LAT_START;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        rsp_err  = 1'b0;
        rsp_inst = '0;
        if (rsp_valid) begin
            rsp_err  = err_q;
            rsp_inst = err_q ? INST_EBREAK : array_word;
        end
    end

endmodule

// File: tb/tb_ysyx_23060187_inst_mem_responder.sv
// Self-checking bench: a LATENCY=2 instance for directed fetch tests and a LATENCY=1 instance
// for the streaming case, both backed by a queue scoreboard fed from a reference memory.
module tb_ysyx_23060187_inst_mem_responder;

    logic        clk;
    logic        rst;
    logic        load_en;
    logic [9:0]  load_addr;
    logic [31:0] load_data;

    logic        a_req_valid, a_req_ready, a_rsp_valid, a_rsp_ready, a_rsp_err;
    logic [31:0] a_req_pc, a_rsp_inst;
    logic        b_req_valid, b_req_ready, b_rsp_valid, b_rsp_ready, b_rsp_err;
    logic [31:0] b_req_pc, b_rsp_inst;

    int          checkCount = 0;
    int          passCount  = 0;
    logic [31:0] model [1024];
    logic [32:0] qa [$];
    logic [32:0] qb [$];
    logic [32:0] expA, expB;

    ysyx_23060187_inst_mem_responder #(.LATENCY(2)) dut_a (
        .clk(clk), .rst(rst),
        .req_valid(a_req_valid), .req_ready(a_req_ready), .req_pc(a_req_pc),
        .rsp_valid(a_rsp_valid), .rsp_ready(a_rsp_ready), .rsp_inst(a_rsp_inst), .rsp_err(a_rsp_err),
        .load_en(load_en), .load_addr(load_addr), .load_data(load_data)
    );

    ysyx_23060187_inst_mem_responder #(.LATENCY(1)) dut_b (
        .clk(clk), .rst(rst),
        .req_valid(b_req_valid), .req_ready(b_req_ready), .req_pc(b_req_pc),
        .rsp_valid(b_rsp_valid), .rsp_ready(b_rsp_ready), .rsp_inst(b_rsp_inst), .rsp_err(b_rsp_err),
        .load_en(load_en), .load_addr(load_addr), .load_data(load_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        checkCount++;
        if (observed !== expected) begin
            $display("[TB] FAIL %s: got %h, expected %h", tag, observed, expected);
        end else begin
            passCount++;
        end
    endtask

    function automatic logic [32:0] expectRsp(input logic [31:0] pc);
        logic [31:0] idx;
        idx = (pc - 32'h8000_0000) >> 2;
        if (pc[1:0] != 2'b00 || idx >= 32'd1024) begin
            return {1'b1, 32'h0010_0073};
        end
        return {1'b0, model[idx[9:0]]};
    endfunction

    // Scoreboard: responses popped on handshake, requests pushed on accept, reference memory
    // updated last so a same-edge load is not seen by the fetch it races.
    always @(negedge clk) begin
        if (!rst) begin
            qa.delete();
            qb.delete();
        end else begin
            if (a_rsp_valid && a_rsp_ready) begin
                if (qa.size() == 0) begin
                    checkOutput("a_sb_nonempty", 64'(qa.size()), 64'd1);
                end else begin
                    expA = qa.pop_front();
                    checkOutput("a_sb_rsp", {31'd0, a_rsp_err, a_rsp_inst}, {31'd0, expA});
                end
            end
            if (a_req_valid && a_req_ready) qa.push_back(expectRsp(a_req_pc));
            if (b_rsp_valid && b_rsp_ready) begin
                if (qb.size() == 0) begin
                    checkOutput("b_sb_nonempty", 64'(qb.size()), 64'd1);
                end else begin
                    expB = qb.pop_front();
                    checkOutput("b_sb_rsp", {31'd0, b_rsp_err, b_rsp_inst}, {31'd0, expB});
                end
            end
            if (b_req_valid && b_req_ready) qb.push_back(expectRsp(b_req_pc));
        end
        if (load_en) model[load_addr] = load_data;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic [9:0] idx, input logic [31:0] data);
        load_en   = 1'b1;
        load_addr = idx;
        load_data = data;
        tick();
        load_en = 1'b0;
    endtask

    task automatic fetchA(input string tag, input logic [31:0] pc, input logic [31:0] expInst, input logic expErr);
        a_req_valid = 1'b1;
        a_req_pc    = pc;
        a_rsp_ready = 1'b1;
        tick();
        load_en     = 1'b0;
        a_req_valid = 1'b0;
        checkOutput({tag, "_wait"}, a_rsp_valid, 1'b0);
        tick();
        checkOutput({tag, "_valid"}, a_rsp_valid, 1'b1);
        checkOutput({tag, "_inst"}, a_rsp_inst, expInst);
        checkOutput({tag, "_err"}, a_rsp_err, expErr);
        tick();
        checkOutput({tag, "_idle"}, a_rsp_valid, 1'b0);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        for (int i = 0; i < 1024; i++) model[i] = 32'h0;
        rst = 1'b0;
        load_en = 1'b0; load_addr = '0; load_data = '0;
        a_req_valid = 1'b0; a_req_pc = '0; a_rsp_ready = 1'b1;
        b_req_valid = 1'b0; b_req_pc = '0; b_rsp_ready = 1'b1;

        tick();
        applyStimulus(10'd0, 32'h0050_0093);
        applyStimulus(10'd1, 32'h1000_0001);
        applyStimulus(10'd2, 32'h1000_0002);
        applyStimulus(10'd3, 32'h1111_1111);
        checkOutput("rst_rsp_valid", a_rsp_valid, 1'b0);
        checkOutput("rst_rsp_inst", a_rsp_inst, 32'h0);
        checkOutput("rst_rsp_err", a_rsp_err, 1'b0);
        checkOutput("rst_req_ready", a_req_ready, 1'b1);
        checkOutput("rst_b_rsp_valid", b_rsp_valid, 1'b0);
        rst = 1'b1;
        tick();

        $display("[TB] basic fetch, latency 2");
        fetchA("basic", 32'h8000_0000, 32'h0050_0093, 1'b0);

        $display("[TB] error fetches");
        fetchA("misalign", 32'h8000_0002, 32'h0010_0073, 1'b1);
        fetchA("range", 32'h8000_1000, 32'h0010_0073, 1'b1);
        fetchA("last_ok", 32'h8000_0008, 32'h1000_0002, 1'b0);

        $display("[TB] streaming, latency 1");
        b_rsp_ready = 1'b1;
        b_req_valid = 1'b1;
        b_req_pc    = 32'h8000_0000;
        tick();
        checkOutput("stream0_valid", b_rsp_valid, 1'b1);
        checkOutput("stream0_inst", b_rsp_inst, 32'h0050_0093);
        checkOutput("stream0_ready", b_req_ready, 1'b1);
        b_req_pc = 32'h8000_0004;
        tick();
        checkOutput("stream1_valid", b_rsp_valid, 1'b1);
        checkOutput("stream1_inst", b_rsp_inst, 32'h1000_0001);
        checkOutput("stream1_ready", b_req_ready, 1'b1);
        b_req_pc = 32'h8000_0008;
        tick();
        checkOutput("stream2_valid", b_rsp_valid, 1'b1);
        checkOutput("stream2_inst", b_rsp_inst, 32'h1000_0002);
        checkOutput("stream2_ready", b_req_ready, 1'b1);
        b_req_valid = 1'b0;
        tick();
        checkOutput("stream_idle", b_rsp_valid, 1'b0);

        $display("[TB] backpressure");
        a_rsp_ready = 1'b0;
        a_req_valid = 1'b1;
        a_req_pc    = 32'h8000_0004;
        tick();
        a_req_pc = 32'h8000_0008;
        checkOutput("bp_wait_ready", a_req_ready, 1'b0);
        tick();
        for (int i = 0; i < 5; i++) begin
            checkOutput("bp_valid", a_rsp_valid, 1'b1);
            checkOutput("bp_inst", a_rsp_inst, 32'h1000_0001);
            checkOutput("bp_ready", a_req_ready, 1'b0);
            tick();
        end
        a_req_valid = 1'b0;
        a_rsp_ready = 1'b1;
        #1;
        checkOutput("bp_release_ready", a_req_ready, 1'b1);
        tick();
        checkOutput("bp_no_dup", a_rsp_valid, 1'b0);

        $display("[TB] same-edge load and fetch");
        load_en   = 1'b1;
        load_addr = 10'd3;
        load_data = 32'hDEAD_BEEF;
        fetchA("same_edge", 32'h8000_000C, 32'h1111_1111, 1'b0);
        fetchA("refetch", 32'h8000_000C, 32'hDEAD_BEEF, 1'b0);

        $display("[TB] reset during wait");
        a_req_valid = 1'b1;
        a_req_pc    = 32'h8000_0004;
        tick();
        a_req_valid = 1'b0;
        rst = 1'b0;
        tick();
        checkOutput("midrst_valid", a_rsp_valid, 1'b0);
        checkOutput("midrst_ready", a_req_ready, 1'b1);
        checkOutput("midrst_inst", a_rsp_inst, 32'h0);
        rst = 1'b1;
        tick();
        tick();
        checkOutput("midrst_no_stale", a_rsp_valid, 1'b0);
        fetchA("retained", 32'h8000_0000, 32'h0050_0093, 1'b0);

        tick();
        checkOutput("a_sb_empty", 64'(qa.size()), 64'd0);
        checkOutput("b_sb_empty", 64'(qb.size()), 64'd0);
        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
